// File: rtl/boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Frame: LEN_HI, LEN_LO, 2N data bytes (MSB first), XOR checksum.
package boot_pkg;

  localparam int WORD_W = 16;

  // Length and each data word arrive most-significant byte first.
  localparam bit MSB_FIRST = 1'b1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN_HI  = 3'd1,
    LEN_LO  = 3'd2,
    DATA_HI = 3'd3,
    DATA_LO = 3'd4,
    CSUM    = 3'd5,
    DONE    = 3'd6,
    ERR     = 3'd7
  } boot_state_t;

  function automatic logic [WORD_W-1:0] pack_word(
    input logic [7:0] first,
    input logic [7:0] second
  );
    return MSB_FIRST ? {first, second} : {second, first};
  endfunction

endpackage

// File: rtl/boot_csum_acc.sv
// Running XOR over the accepted frame bytes.
// match compares the current input byte against the running value.
module boot_csum_acc (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] din,
  output logic       match
);

  logic [7:0] acc;

  // Accumulate XOR of every enabled byte; clear wins over enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= 8'h00;
    end else if (clr) begin
      acc <= 8'h00;
    end else if (en) begin
      acc <= acc ^ din;
    end
  end

  assign match = (din == acc);

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: holds the CPU in reset while a framed byte stream
// is checked and written into instruction memory as 16-bit words.
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int          MAX_WORDS = 256,
  parameter logic [15:0] BASE_ADDR = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [15:0]       imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_loaded
);

  localparam int LAST_ADDR = int'(BASE_ADDR) + 2 * (MAX_WORDS - 1);

  if (MAX_WORDS < 1 || MAX_WORDS > 32768 || LAST_ADDR > 65535) begin : g_bad_cfg
    $error("imem_boot_loader: program window wraps the 16-bit address space");
  end

  boot_state_t state;
  logic [7:0]  len_hi;
  logic [15:0] len;
  logic [7:0]  data_hi;

  logic take;
  logic idle_like;
  logic start_ok;
  logic csum_en;
  logic csum_ok;

  assign take      = rx_valid & rx_ready;
  assign idle_like = (state == IDLE) | (state == DONE) | (state == ERR);
  assign start_ok  = start & idle_like;
  assign csum_en   = take & (state != CSUM);

  boot_csum_acc u_csum (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_ok),
    .en    (csum_en),
    .din   (rx_data),
    .match (csum_ok)
  );

  // Frame FSM with registered handshake, write port and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      rx_ready     <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= BASE_ADDR;
      imem_wdata   <= '0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
      len_hi       <= '0;
      len          <= '0;
      data_hi      <= '0;
    end else begin
      imem_we <= 1'b0;
      unique case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state        <= LEN_HI;
            rx_ready     <= 1'b1;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
          end
        end
        LEN_HI: begin
          if (take) begin
            len_hi <= rx_data;
            state  <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (take) begin
            len <= pack_word(len_hi, rx_data);
            if (int'(pack_word(len_hi, rx_data)) > MAX_WORDS) begin
              state    <= ERR;
              rx_ready <= 1'b0;
              error    <= 1'b1;
            end else if (pack_word(len_hi, rx_data) == 16'd0) begin
              state <= CSUM;
            end else begin
              state <= DATA_HI;
            end
          end
        end
        DATA_HI: begin
          if (take) begin
            data_hi <= rx_data;
            state   <= DATA_LO;
          end
        end
        DATA_LO: begin
          if (take) begin
            imem_we      <= 1'b1;
            imem_wdata   <= pack_word(data_hi, rx_data);
            imem_addr    <= BASE_ADDR + {words_loaded[14:0], 1'b0};
            words_loaded <= words_loaded + 16'd1;
            if (words_loaded + 16'd1 < len) begin
              state <= DATA_HI;
            end else begin
              state <= CSUM;
            end
          end
        end
        CSUM: begin
          if (take) begin
            rx_ready <= 1'b0;
            if (csum_ok) begin
              state    <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          rx_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader.
// Each task drives one scenario and checks its own expectations.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        imem_we;
  logic [15:0] imem_addr;
  logic [15:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_acc = 0;

  logic [15:0] wa[$];
  logic [15:0] wd[$];
  int          wc[$];

  imem_boot_loader dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
      wc.push_back(cyc);
    end
  end

  task automatic clear_log();
    wa.delete();
    wd.delete();
    wc.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Idle for gap cycles (optionally pulsing start in the first), then
  // present one byte until it is accepted; returns 1 time unit after
  // the accepting edge with rx_valid dropped.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit kick);
    int n;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      rx_valid = 1'b0;
      start = (kick && i == 0);
    end
    @(negedge clk);
    start = 1'b0;
    rx_valid = 1'b1;
    rx_data = b;
    n = 0;
    while (rx_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_timeout byte=%h rx_ready=%b expected 1", b, rx_ready);
    end
    @(posedge clk);
    #1;
    last_acc = cyc;
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    #12;
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL rst_rx_ready got=%b exp=0", rx_ready); end
    checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL rst_imem_we got=%b exp=0", imem_we); end
    checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL rst_addr got=%h exp=0000", imem_addr); end
    checks++; if (imem_wdata !== 16'h0000) begin errors++; $display("FAIL rst_wdata got=%h exp=0000", imem_wdata); end
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL rst_cpu_hold got=%b exp=1", cpu_hold); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", done); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL rst_error got=%b exp=0", error); end
    checks++; if (words_loaded !== 16'd0) begin errors++; $display("FAIL rst_words got=%0d exp=0", words_loaded); end
    @(negedge clk);
    rst = 1'b0;
    rx_valid = 1'b1;
    rx_data = 8'h55;
    repeat (3) @(negedge clk);
    rx_valid = 1'b0;
    checks++; if (rx_ready !== 1'b0 || cpu_hold !== 1'b1) begin
      errors++; $display("FAIL idle_hold rx_ready=%b cpu_hold=%b exp 0/1", rx_ready, cpu_hold);
    end
  endtask

  task automatic test_good_frame();
    clear_log();
    pulse_start();
    checks++; if (rx_ready !== 1'b1 || cpu_hold !== 1'b1) begin
      errors++; $display("FAIL good_start rx_ready=%b cpu_hold=%b exp 1/1", rx_ready, cpu_hold);
    end
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h02, 0, 1'b0);
    send_byte(8'h12, 0, 1'b0);
    send_byte(8'h34, 0, 1'b0);
    checks++; if (imem_we !== 1'b1 || imem_addr !== 16'h0000 || imem_wdata !== 16'h1234) begin
      errors++; $display("FAIL good_w0 we=%b addr=%h data=%h exp 1/0000/1234", imem_we, imem_addr, imem_wdata);
    end
    checks++; if (words_loaded !== 16'd1) begin errors++; $display("FAIL good_wl1 got=%0d exp=1", words_loaded); end
    send_byte(8'hAB, 0, 1'b0);
    send_byte(8'hCD, 0, 1'b0);
    checks++; if (imem_we !== 1'b1 || imem_addr !== 16'h0002 || imem_wdata !== 16'hABCD) begin
      errors++; $display("FAIL good_w1 we=%b addr=%h data=%h exp 1/0002/abcd", imem_we, imem_addr, imem_wdata);
    end
    checks++; if (cpu_hold !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL good_precsum cpu_hold=%b done=%b exp 1/0", cpu_hold, done);
    end
    // xor of 00 02 12 34 ab cd
    send_byte(8'h42, 0, 1'b0);
    checks++; if (done !== 1'b1 || cpu_hold !== 1'b0 || error !== 1'b0) begin
      errors++; $display("FAIL good_done done=%b cpu_hold=%b error=%b exp 1/0/0", done, cpu_hold, error);
    end
    checks++; if (words_loaded !== 16'd2) begin errors++; $display("FAIL good_words got=%0d exp=2", words_loaded); end
    checks++; if (wa.size() != 2) begin errors++; $display("FAIL good_nwr got=%0d exp=2", wa.size()); end
    else if (wc[1] - wc[0] != 2) begin errors++; $display("FAIL good_spacing got=%0d exp=2", wc[1] - wc[0]); end
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL good_rdy_off got=%b exp=0", rx_ready); end
  endtask

  task automatic test_bad_csum();
    clear_log();
    pulse_start();
    checks++; if (cpu_hold !== 1'b1 || done !== 1'b0 || words_loaded !== 16'd0) begin
      errors++; $display("FAIL restart cpu_hold=%b done=%b wl=%0d exp 1/0/0", cpu_hold, done, words_loaded);
    end
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h02, 0, 1'b0);
    send_byte(8'h12, 0, 1'b0);
    send_byte(8'h34, 0, 1'b0);
    send_byte(8'hAB, 0, 1'b0);
    send_byte(8'hCD, 0, 1'b0);
    send_byte(8'h41, 0, 1'b0);
    @(negedge clk);
    checks++; if (error !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1) begin
      errors++; $display("FAIL bad_csum error=%b done=%b cpu_hold=%b exp 1/0/1", error, done, cpu_hold);
    end
    checks++; if (wa.size() != 2) begin errors++; $display("FAIL bad_nwr got=%0d exp=2", wa.size()); end
    else if (wd[0] !== 16'h1234 || wd[1] !== 16'hABCD) begin
      errors++; $display("FAIL bad_data got=%h,%h exp 1234,abcd", wd[0], wd[1]);
    end
  endtask

  task automatic test_zero_len();
    clear_log();
    pulse_start();
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    @(negedge clk);
    checks++; if (done !== 1'b1 || error !== 1'b0 || cpu_hold !== 1'b0) begin
      errors++; $display("FAIL zero_done done=%b error=%b cpu_hold=%b exp 1/0/0", done, error, cpu_hold);
    end
    checks++; if (wa.size() != 0 || words_loaded !== 16'd0) begin
      errors++; $display("FAIL zero_nwr writes=%0d wl=%0d exp 0/0", wa.size(), words_loaded);
    end
  endtask

  task automatic test_overlen();
    clear_log();
    pulse_start();
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'h01, 0, 1'b0);
    checks++; if (error !== 1'b1 || rx_ready !== 1'b0 || cpu_hold !== 1'b1) begin
      errors++; $display("FAIL overlen error=%b rx_ready=%b cpu_hold=%b exp 1/0/1", error, rx_ready, cpu_hold);
    end
    repeat (3) @(negedge clk);
    checks++; if (wa.size() != 0 || done !== 1'b0) begin
      errors++; $display("FAIL overlen_nwr writes=%0d done=%b exp 0/0", wa.size(), done);
    end
  endtask

  task automatic test_gaps();
    int a34;
    int acd;
    clear_log();
    pulse_start();
    send_byte(8'h00, 2, 1'b0);
    send_byte(8'h02, 1, 1'b1);
    send_byte(8'h12, 3, 1'b0);
    send_byte(8'h34, 0, 1'b0);
    a34 = last_acc;
    send_byte(8'hAB, 1, 1'b1);
    send_byte(8'hCD, 3, 1'b0);
    acd = last_acc;
    send_byte(8'h42, 2, 1'b1);
    @(negedge clk);
    checks++; if (done !== 1'b1 || error !== 1'b0 || words_loaded !== 16'd2) begin
      errors++; $display("FAIL gap_done done=%b error=%b wl=%0d exp 1/0/2", done, error, words_loaded);
    end
    checks++; if (wa.size() != 2) begin errors++; $display("FAIL gap_nwr got=%0d exp=2", wa.size()); end
    else begin
      if (wa[0] !== 16'h0000 || wd[0] !== 16'h1234 || wa[1] !== 16'h0002 || wd[1] !== 16'hABCD) begin
        errors++;
        $display("FAIL gap_data got=%h@%h,%h@%h exp 1234@0000,abcd@0002", wd[0], wa[0], wd[1], wa[1]);
      end
      checks++;
      if (wc[0] != a34 || wc[1] != acd || wc[1] - wc[0] != 6) begin
        errors++;
        $display("FAIL gap_timing got=%0d,%0d exp=%0d,%0d (delta 6)", wc[0], wc[1], a34, acd);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_log();
    pulse_start();
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h02, 0, 1'b0);
    send_byte(8'h12, 0, 1'b0);
    send_byte(8'h34, 0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (rx_ready !== 1'b0 || imem_we !== 1'b0 || cpu_hold !== 1'b1) begin
      errors++; $display("FAIL midrst_ctl rx_ready=%b we=%b cpu_hold=%b exp 0/0/1", rx_ready, imem_we, cpu_hold);
    end
    checks++; if (imem_addr !== 16'h0000 || imem_wdata !== 16'h0000 || words_loaded !== 16'd0) begin
      errors++; $display("FAIL midrst_data addr=%h wdata=%h wl=%0d exp 0000/0000/0", imem_addr, imem_wdata, words_loaded);
    end
    checks++; if (done !== 1'b0 || error !== 1'b0) begin
      errors++; $display("FAIL midrst_flags done=%b error=%b exp 0/0", done, error);
    end
    @(negedge clk);
    rst = 1'b0;
    clear_log();
    pulse_start();
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h02, 0, 1'b0);
    send_byte(8'h12, 0, 1'b0);
    send_byte(8'h34, 0, 1'b0);
    send_byte(8'hAB, 0, 1'b0);
    send_byte(8'hCD, 0, 1'b0);
    send_byte(8'h42, 0, 1'b0);
    checks++; if (done !== 1'b1 || cpu_hold !== 1'b0 || words_loaded !== 16'd2) begin
      errors++; $display("FAIL midrst_reload done=%b cpu_hold=%b wl=%0d exp 1/0/2", done, cpu_hold, words_loaded);
    end
    checks++; if (wa.size() != 2) begin errors++; $display("FAIL midrst_nwr got=%0d exp=2", wa.size()); end
    else if (wa[1] !== 16'h0002 || wd[1] !== 16'hABCD) begin
      errors++; $display("FAIL midrst_w1 got=%h@%h exp abcd@0002", wd[1], wa[1]);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_zero_len();
    test_overlen();
    test_gaps();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
